// File: rtl/countdown_timer_core_pkg.sv
// rtl/countdown_timer_core_pkg.sv - shared state encodings, BCD limits and preset clamping
package countdown_timer_core_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } timer_state_t;

    localparam logic [3:0]  DIGIT_MAX    = 4'd9;
    localparam logic [3:0]  SEC_TENS_MAX = 4'd5;
    localparam logic [15:0] TIME_ZERO    = 16'h0000;
    localparam logic [15:0] TIME_ONE     = 16'h0001;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

    // Preset layout {min_tens, min_ones, sec_tens, sec_ones}; out-of-range digits saturate.
    function automatic logic [15:0] clamp_preset(input logic [15:0] p);
        return {clamp_digit(p[15:12], DIGIT_MAX),
                clamp_digit(p[11:8],  DIGIT_MAX),
                clamp_digit(p[7:4],   SEC_TENS_MAX),
                clamp_digit(p[3:0],   DIGIT_MAX)};
    endfunction

endpackage

// File: rtl/countdown_timer_core_bcd_down_digit.sv
// rtl/countdown_timer_core_bcd_down_digit.sv - one loadable BCD down-counting digit with borrow out
module bcd_down_digit
    import countdown_timer_core_pkg::*;
#(
    parameter logic [3:0] WRAP = DIGIT_MAX
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dec_en,
    input  logic       load,
    input  logic [3:0] load_value,
    output logic [3:0] digit,
    output logic       borrow_out
);

    assign borrow_out = dec_en && (digit == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit <= 4'd0;
        end else if (load) begin
            digit <= load_value;
        end else if (dec_en) begin
            digit <= (digit == 4'd0) ? WRAP : digit - 4'd1;
        end
    end

endmodule

// File: rtl/countdown_timer_core.sv
// rtl/countdown_timer_core.sv - mm:ss BCD countdown engine with run/pause/done control and 1 s prescaler
module countdown_timer_core
    import countdown_timer_core_pkg::*;
#(
    parameter int TICK_DIV = 50000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    input  logic        load,
    input  logic [15:0] preset,
    output logic [3:0]  min_tens,
    output logic [3:0]  min_ones,
    output logic [3:0]  sec_tens,
    output logic [3:0]  sec_ones,
    output logic        running,
    output logic        done,
    output logic        expired
);

    localparam int              CNT_W     = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);

    timer_state_t     state_q, state_d;
    logic [CNT_W-1:0] prescaler_q;
    logic             running_d, done_d, expired_d;

    logic [3:0]  dig [4];
    logic [4:0]  borrow;
    logic [15:0] value;
    logic [15:0] preset_clamped;
    logic        value_zero;
    logic        tick;
    logic        load_ok;
    logic        start_ok;
    logic        stop_ok;
    logic        reach_zero;

    assign value          = {dig[3], dig[2], dig[1], dig[0]};
    assign preset_clamped = clamp_preset(preset);
    assign value_zero     = (value == TIME_ZERO);
    assign tick           = (state_q == ST_RUN) && (prescaler_q == TICK_LAST);

    assign load_ok    = load && (state_q != ST_RUN);
    assign start_ok   = start && !load && !value_zero &&
                        ((state_q == ST_IDLE) || (state_q == ST_PAUSE));
    assign stop_ok    = stop && (state_q == ST_RUN);
    assign reach_zero = tick && (value == TIME_ONE);

    // A decrement never starts from 00:00, so the seconds digit only sees dec_en when nonzero.
    assign borrow[0] = tick && !value_zero;

    for (genvar i = 0; i < 4; i++) begin : g_digit
        bcd_down_digit #(
            .WRAP((i == 1) ? SEC_TENS_MAX : DIGIT_MAX)
        ) u_digit (
            .clk        (clk),
            .rst_n      (rst_n),
            .dec_en     (borrow[i]),
            .load       (load_ok),
            .load_value (preset_clamped[i*4 +: 4]),
            .digit      (dig[i]),
            .borrow_out (borrow[i+1])
        );
    end

    assign sec_ones = dig[0];
    assign sec_tens = dig[1];
    assign min_ones = dig[2];
    assign min_tens = dig[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            running <= 1'b0;
            done    <= 1'b0;
            expired <= 1'b0;
        end else begin
            state_q <= state_d;
            running <= running_d;
            done    <= done_d;
            expired <= expired_d;
        end
    end

    // A tick coinciding with stop still decrements; reaching zero overrides the pause.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE, ST_PAUSE: begin
                if (load_ok) begin
                    state_d = ST_IDLE;
                end else if (start_ok) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (reach_zero || borrow[4]) begin
                    state_d = ST_DONE;
                end else if (stop_ok) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_DONE: begin
                if (load_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        running_d = (state_d == ST_RUN);
        done_d    = (state_d == ST_DONE);
        expired_d = (state_d == ST_DONE) && (state_q != ST_DONE);
    end

    // Resume from PAUSE keeps the partial second; a fresh start or load restarts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_q <= '0;
        end else if (load_ok || (start_ok && (state_q == ST_IDLE))) begin
            prescaler_q <= '0;
        end else if (state_q == ST_RUN) begin
            prescaler_q <= tick ? '0 : prescaler_q + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_countdown_timer_core.sv
// tb/tb_countdown_timer_core.sv - self-checking bench: vector table, directed corner cases, random vs. model
module tb_countdown_timer_core;

    localparam int TICK_DIV = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        load;
    logic [15:0] preset;
    logic [3:0]  min_tens, min_ones, sec_tens, sec_ones;
    logic        running, done, expired;

    int tests;
    int fails;

    countdown_timer_core #(.TICK_DIV(TICK_DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .load     (load),
        .preset   (preset),
        .min_tens (min_tens),
        .min_ones (min_ones),
        .sec_tens (sec_tens),
        .sec_ones (sec_ones),
        .running  (running),
        .done     (done),
        .expired  (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: remaining time as whole seconds, state as a small integer.
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
    int m_secs;
    int m_state;
    int m_cnt;
    bit m_exp;

    function automatic int preset_to_secs(input logic [15:0] p);
        int mt, mo, st, so;
        mt = (p[15:12] > 9) ? 9 : int'(p[15:12]);
        mo = (p[11:8]  > 9) ? 9 : int'(p[11:8]);
        st = (p[7:4]   > 5) ? 5 : int'(p[7:4]);
        so = (p[3:0]   > 9) ? 9 : int'(p[3:0]);
        return (mt * 10 + mo) * 60 + st * 10 + so;
    endfunction

    function automatic logic [15:0] secs_to_bcd(input int s);
        int mm, ss;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic model_reset();
        m_secs = 0; m_state = M_IDLE; m_cnt = 0; m_exp = 0;
    endtask

    task automatic model_step(input bit ld, input bit st, input bit sp, input logic [15:0] pr);
        bit tk;
        m_exp = 0;
        tk = (m_state == M_RUN) && (m_cnt == TICK_DIV - 1);
        if (ld && m_state != M_RUN) begin
            m_secs = preset_to_secs(pr); m_state = M_IDLE; m_cnt = 0;
        end else if (st && (m_state == M_IDLE || m_state == M_PAUSE) && m_secs != 0) begin
            if (m_state == M_IDLE) m_cnt = 0;
            m_state = M_RUN;
        end else if (m_state == M_RUN) begin
            if (tk) begin
                m_cnt = 0;
                m_secs = m_secs - 1;
                if (m_secs == 0) begin
                    m_state = M_DONE; m_exp = 1;
                end else if (sp) begin
                    m_state = M_PAUSE;
                end
            end else begin
                m_cnt = m_cnt + 1;
                if (sp) m_state = M_PAUSE;
            end
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] shown();
        return {min_tens, min_ones, sec_tens, sec_ones};
    endfunction

    task automatic step(input bit ld, input bit st, input bit sp, input logic [15:0] pr);
        load = ld; start = st; stop = sp; preset = pr;
        @(posedge clk);
        #1;
        model_step(ld, st, sp, pr);
        load = 0; start = 0; stop = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 16'h0);
    endtask

    typedef struct {
        logic [15:0] preset;
        logic [15:0] expect_val;
    } clamp_vec_t;

    clamp_vec_t vecs[8];

    initial begin
        tests = 0; fails = 0;
        model_reset();
        vecs[0] = '{16'hAF6C, 16'h9959};
        vecs[1] = '{16'h1234, 16'h1234};
        vecs[2] = '{16'h9999, 16'h9959};
        vecs[3] = '{16'hFFFF, 16'h9959};
        vecs[4] = '{16'h0A5B, 16'h0959};
        vecs[5] = '{16'h7070, 16'h7050};
        vecs[6] = '{16'h0000, 16'h0000};
        vecs[7] = '{16'h5959, 16'h5959};

        rst_n = 0; start = 0; stop = 0; load = 0; preset = 16'h0;
        #12;
        check("reset_digits", shown(), 16'h0000);
        check("reset_flags", {running, done, expired}, 3'b000);
        #1 rst_n = 1;

        // Basic run from 00:03
        step(1, 0, 0, 16'h0003);
        check("basic_loaded", shown(), 16'h0003);
        step(0, 1, 0, 16'h0);
        check("basic_running", running, 1'b1);
        idle(3);
        check("basic_before_tick", shown(), 16'h0003);
        idle(1);
        check("basic_t4", shown(), 16'h0002);
        idle(4);
        check("basic_t8", shown(), 16'h0001);
        idle(4);
        check("basic_t12", shown(), 16'h0000);
        check("basic_done_flags", {running, done, expired}, 3'b011);
        idle(1);
        check("basic_expired_once", {running, done, expired}, 3'b010);

        // Borrow chain
        step(1, 0, 0, 16'h1000);
        step(0, 1, 0, 16'h0);
        idle(4);
        check("borrow_1000", shown(), 16'h0959);
        step(0, 0, 1, 16'h0);
        step(1, 0, 0, 16'h0100);
        step(0, 1, 0, 16'h0);
        idle(4);
        check("borrow_0100", shown(), 16'h0059);
        step(1, 0, 0, 16'h0500);
        check("run_load_ignored", {shown(), 3'(running)}, {16'h0059, 3'b1});
        idle(3);
        check("run_load_continues", shown(), 16'h0058);
        step(0, 0, 1, 16'h0);

        // Pause and resume with preserved prescaler
        step(1, 0, 0, 16'h0005);
        step(0, 1, 0, 16'h0);
        idle(1);
        step(0, 0, 1, 16'h0);
        idle(20);
        check("pause_hold", {shown(), 3'(running)}, {16'h0005, 3'b0});
        step(0, 1, 0, 16'h0);
        check("resume_running", {shown(), 3'(running)}, {16'h0005, 3'b1});
        idle(1);
        check("resume_t1", shown(), 16'h0005);
        idle(1);
        check("resume_t2", shown(), 16'h0004);
        step(0, 0, 1, 16'h0);

        // Clamp vectors
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 0, vecs[i].preset);
            check($sformatf("clamp_%0d", i), {shown(), 3'(running), 3'(done)},
                  {vecs[i].expect_val, 3'b0, 3'b0});
        end

        // Start at 00:00 ignored
        step(1, 0, 0, 16'h0000);
        step(0, 1, 0, 16'h0);
        idle(5);
        check("zero_start_ignored", {shown(), 1'(running), 1'(done)}, {16'h0000, 2'b00});

        // DONE ignores start, load returns to IDLE
        step(1, 0, 0, 16'h0001);
        step(0, 1, 0, 16'h0);
        idle(4);
        check("done_reached", {running, done, expired}, 3'b011);
        step(0, 1, 0, 16'h0);
        check("done_start_ignored", {running, done, expired}, 3'b010);
        step(1, 0, 0, 16'h0002);
        check("done_load", {shown(), 1'(running), 1'(done)}, {16'h0002, 2'b00});

        // Stop on the tick that reaches zero: DONE wins
        step(0, 1, 0, 16'h0);
        idle(4);
        check("tick_stop_pre", shown(), 16'h0001);
        idle(3);
        step(0, 0, 1, 16'h0);
        check("tick_stop_done", {shown(), 1'(running), 1'(done), 1'(expired)}, {16'h0000, 3'b011});

        // Stop on a nonzero tick: decrement then PAUSE; then load+start from PAUSE
        step(1, 0, 0, 16'h0003);
        step(0, 1, 0, 16'h0);
        idle(3);
        step(0, 0, 1, 16'h0);
        check("tick_stop_pause", {shown(), 1'(running), 1'(done)}, {16'h0002, 2'b00});
        step(1, 1, 0, 16'h0042);
        idle(6);
        check("load_start_idle", {shown(), 1'(running)}, {16'h0042, 1'b0});

        // Asynchronous reset mid-RUN
        step(1, 0, 0, 16'h0030);
        step(0, 1, 0, 16'h0);
        idle(2);
        #3 rst_n = 0;
        #1;
        check("async_reset", {shown(), 1'(running), 1'(done), 1'(expired)}, {16'h0000, 3'b000});
        #2 rst_n = 1;

        // Randomized run against the model
        @(posedge clk); #1;
        rst_n = 0; #2 rst_n = 1;
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            bit ld, st, sp;
            logic [15:0] pr;
            ld = ($urandom_range(0, 99) < 4);
            st = ($urandom_range(0, 99) < 12);
            sp = ($urandom_range(0, 99) < 6);
            if ($urandom_range(0, 1) == 0) pr = {12'h0, 4'($urandom_range(0, 4))};
            else pr = 16'($urandom);
            step(ld, st, sp, pr);
            check($sformatf("random_%0d", i),
                  {shown(), 1'(running), 1'(done), 1'(expired)},
                  {secs_to_bcd(m_secs), 1'(m_state == M_RUN), 1'(m_state == M_DONE), 1'(m_exp)});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
